i2c_master_ctrl: RTL
====================

I2C_MASTER_CTRL -- requirements
Module: i2c_master_ctrl

Interface
REQ-001 SHALL have parameter MESSAGE_LENGTH, default 8: payload bits per transaction; a multiple of 8, from 8 to 32.
REQ-002 SHALL have parameter CLK_DIV, default 4: clk cycles per SCL quarter-period; minimum 2.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1 bit: transaction request, accepted only when idle.
REQ-006 SHALL have ports addr (input, 7 bits, slave address) and rw (input, 1 bit; 0=write, 1=read).
REQ-007 SHALL have port data, input, MESSAGE_LENGTH bits: write payload, MSB first.
REQ-008 SHALL have port rdata, output, MESSAGE_LENGTH bits: read payload, MSB first.
REQ-009 SHALL have outputs busy, done and ack_err, each 1 bit.
REQ-010 SHALL have port scl, output, 1 bit: I2C clock.
REQ-011 SHALL have ports sda_oe (output, 1 bit; 1 = drive SDA low, 0 = release) and sda_i (input, 1 bit; sampled bus level).

Function
REQ-012 SHALL, when start=1 and busy=0 on a clk edge, latch addr, rw and data; busy SHALL read 1 from the next cycle.
REQ-013 SHALL ignore start while busy=1; latched values SHALL NOT change mid-transaction.
REQ-014 SHALL split every bit period into four quarters of CLK_DIV cycles each: Q0 SCL low with SDA updated, Q1–Q2 SCL high with sda_i sampled on the last cycle of Q2, Q3 SCL low.
REQ-015 SHALL use states IDLE, START, ADDR, ADDR_ACK, DATA, DATA_ACK, STOP and DONE.
REQ-016 SHALL run IDLE → START → ADDR → ADDR_ACK, then DATA → DATA_ACK once per byte, then STOP → DONE → IDLE.
REQ-017 START: SDA SHALL fall while SCL is high, then SCL SHALL fall.
REQ-018 STOP: SDA SHALL rise while SCL is high.
REQ-019 ADDR SHALL send addr[6:0] followed by rw, 8 bits MSB first.
REQ-020 ADDR_ACK and write DATA_ACK SHALL release SDA; sda_i=1 at the sample point is a NACK.
REQ-021 On NACK the block SHALL go directly to STOP, set ack_err=1 and skip all remaining bytes.
REQ-022 Read DATA SHALL release SDA and shift sda_i into rdata; the master SHALL drive ACK (sda_oe=1) after each byte except the last, which gets NACK.
REQ-023 SHALL assert done for exactly one cycle in DONE; busy SHALL drop in the same cycle.
REQ-024 ack_err SHALL be valid from done until the next accepted start, which clears it.
REQ-025 With no NACK and no stretching, latency from the accept edge to done SHALL be (2 + 9*(1 + MESSAGE_LENGTH/8)) * 4 * CLK_DIV cycles.
REQ-026 rdata SHALL hold its last value on write transactions and after NACK.

Reset
REQ-027 reset=0 SHALL immediately force: state IDLE, scl=1, sda_oe=0, busy=0, done=0, ack_err=0, rdata=0, divider counter 0.
REQ-028 Reset mid-transaction SHALL abort without generating STOP; after reset=1, operation SHALL resume in IDLE.

Configuration
REQ-029 With macro I2C_CLK_STRETCH_EN defined, the block SHALL add input scl_i and SHALL hold Q1 (no counter advance) while scl_i=0 (slave clock stretching).
REQ-030 Without I2C_CLK_STRETCH_EN, there SHALL be no scl_i port, and timing SHALL be purely counter-driven.

Structure
REQ-031 Package i2c_pkg SHALL hold the state enum, the quarter-phase encoding and the constant ADDR_BITS=7.
REQ-032 Sub-module i2c_clk_gen SHALL produce the quarter-phase tick and phase index from CLK_DIV, including the stretch hold.

Verification
REQ-033 Write 0x5F to address 0x2A, slave ACKs all: bus shows START, 0x54, ACK, 0x5F, ACK, STOP; done after 320 cycles (CLK_DIV=4); ack_err=0.
REQ-034 Address NACK (sda_i=1 in ADDR_ACK): STOP follows immediately; done after 192 cycles; ack_err=1.
REQ-035 Read, MESSAGE_LENGTH=16, slave returns 0x95F0: rdata=0x95F0; master ACKs the first byte and NACKs the second.
REQ-036 Pulse start while busy with data=0x0F: transmitted byte stays 0x5F; a single done pulse.
REQ-037 Assert reset during byte 1: scl=1 and sda_oe=0 in the same cycle; a following write of 0xF0 completes normally.
REQ-038 With I2C_CLK_STRETCH_EN, hold scl_i=0 for 50 cycles in ADDR bit 3: latency grows by exactly 50 cycles; data is unchanged.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C master: FSM states, quarter-phase encoding
// and the 7-bit slave address width.
package i2c_pkg;

    localparam int ADDR_BITS = 7;

    typedef enum logic [2:0] {
        IDLE,
        START,
        ADDR,
        ADDR_ACK,
        DATA,
        DATA_ACK,
        STOP,
        DONE
    } state_t;

    // Q0: SCL low, SDA changes; Q1-Q2: SCL high; Q3: SCL low.
    typedef enum logic [1:0] {
        Q0,
        Q1,
        Q2,
        Q3
    } phase_t;

endpackage

// File: rtl/i2c_clk_gen.sv
// Quarter-phase timebase for the I2C master: a tick on the last clk cycle of
// each CLK_DIV-long quarter, plus the index of the current quarter.
module i2c_clk_gen
    import i2c_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   run,
    input  logic   hold,
    output logic   tick,
    output phase_t phase
);

    localparam int CW = $clog2(CLK_DIV);

    logic [CW-1:0] cnt;
    logic          stall;

    // A stretching slave freezes the timebase only while SCL should be high (Q1).
    assign stall = hold && (phase == Q1);
    assign tick  = run && !stall && (cnt == CW'(CLK_DIV - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt   <= '0;
            phase <= Q0;
        end else if (!run) begin
            cnt   <= '0;
            phase <= Q0;
        end else if (tick) begin
            cnt   <= '0;
            phase <= phase_t'(phase + 2'd1);
        end else if (!stall) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/i2c_master_ctrl.sv
// Single-transaction I2C master: START, address+rw, MESSAGE_LENGTH/8 data bytes, STOP.
// Optional slave clock stretching is compiled in with I2C_CLK_STRETCH_EN.
module i2c_master_ctrl
    import i2c_pkg::*;
#(
    parameter int MESSAGE_LENGTH = 8,
    parameter int CLK_DIV        = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [ADDR_BITS-1:0]      addr,
    input  logic                      rw,
    input  logic [MESSAGE_LENGTH-1:0] data,
    output logic [MESSAGE_LENGTH-1:0] rdata,
    output logic                      busy,
    output logic                      done,
    output logic                      ack_err,
    output logic                      scl,
    output logic                      sda_oe,
    input  logic                      sda_i,
`ifdef I2C_CLK_STRETCH_EN
    input  logic                      scl_i,
`endif
    output logic [2:0]                fsm_state
);

    localparam int NBYTES = MESSAGE_LENGTH / 8;

    state_t                    state;
    phase_t                    phase;
    phase_t                    next_q;
    logic                      tick;
    logic                      hold;
    logic [7:0]                addr_sr;
    logic [MESSAGE_LENGTH-1:0] tx_sr;
    logic                      rw_q;
    logic                      nack;
    logic                      stop_lead;
    logic [2:0]                bit_cnt;
    logic [1:0]                byte_cnt;
    logic                      last_byte;

`ifdef I2C_CLK_STRETCH_EN
    assign hold = !scl_i;
`else
    assign hold = 1'b0;
`endif

    assign next_q    = phase_t'(phase + 2'd1);
    assign last_byte = (byte_cnt == 2'(NBYTES - 1));
    assign fsm_state = state;

    i2c_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
        .clk   (clk),
        .reset (reset),
        .run   (busy),
        .hold  (hold),
        .tick  (tick),
        .phase (phase)
    );

    // Handshake: start is a request taken on any clk edge where busy=0; busy is
    // the not-ready indication and done pulses once as busy falls.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            scl       <= 1'b1;
            sda_oe    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            ack_err   <= 1'b0;
            rdata     <= '0;
            addr_sr   <= '0;
            tx_sr     <= '0;
            rw_q      <= 1'b0;
            nack      <= 1'b0;
            stop_lead <= 1'b0;
            bit_cnt   <= '0;
            byte_cnt  <= '0;
        end else begin
            done <= 1'b0;
            if (!busy) begin
                if (start) begin
                    addr_sr   <= {addr, rw};
                    tx_sr     <= data;
                    rw_q      <= rw;
                    ack_err   <= 1'b0;
                    stop_lead <= 1'b0;
                    busy      <= 1'b1;
                    scl       <= 1'b1;
                    sda_oe    <= 1'b0;
                    state     <= START;
                end else begin
                    state <= IDLE;
                end
            end else if (tick) begin
                if (phase != Q3) begin
                    if (phase == Q2) begin
                        nack <= sda_i;
                        if (state == DATA && rw_q)
                            rdata <= {rdata[MESSAGE_LENGTH-2:0], sda_i};
                    end
                    case (state)
                        START: begin
                            if (next_q == Q1) sda_oe <= 1'b1;
                            if (next_q == Q3) scl <= 1'b0;
                        end
                        STOP: begin
                            if (!stop_lead) begin
                                if (next_q == Q1) scl <= 1'b1;
                                if (next_q == Q2) sda_oe <= 1'b0;
                            end
                        end
                        default: scl <= (next_q != Q3);
                    endcase
                end else begin
                    scl <= 1'b0;
                    case (state)
                        START: begin
                            state   <= ADDR;
                            bit_cnt <= '0;
                            sda_oe  <= !addr_sr[7];
                            addr_sr <= {addr_sr[6:0], 1'b0};
                        end
                        ADDR: begin
                            if (bit_cnt == 3'd7) begin
                                state  <= ADDR_ACK;
                                sda_oe <= 1'b0;
                            end else begin
                                bit_cnt <= bit_cnt + 3'd1;
                                sda_oe  <= !addr_sr[7];
                                addr_sr <= {addr_sr[6:0], 1'b0};
                            end
                        end
                        ADDR_ACK: begin
                            if (nack) begin
                                state     <= STOP;
                                ack_err   <= 1'b1;
                                stop_lead <= 1'b1;
                                sda_oe    <= 1'b1;
                            end else begin
                                state    <= DATA;
                                bit_cnt  <= '0;
                                byte_cnt <= '0;
                                sda_oe   <= !rw_q && !tx_sr[MESSAGE_LENGTH-1];
                                tx_sr    <= {tx_sr[MESSAGE_LENGTH-2:0], 1'b0};
                            end
                        end
                        DATA: begin
                            if (bit_cnt == 3'd7) begin
                                state  <= DATA_ACK;
                                sda_oe <= rw_q && !last_byte;
                            end else begin
                                bit_cnt <= bit_cnt + 3'd1;
                                sda_oe  <= !rw_q && !tx_sr[MESSAGE_LENGTH-1];
                                tx_sr   <= {tx_sr[MESSAGE_LENGTH-2:0], 1'b0};
                            end
                        end
                        DATA_ACK: begin
                            if (!rw_q && nack) begin
                                state     <= STOP;
                                ack_err   <= 1'b1;
                                stop_lead <= 1'b1;
                                sda_oe    <= 1'b1;
                            end else if (last_byte) begin
                                state  <= STOP;
                                sda_oe <= 1'b1;
                            end else begin
                                state    <= DATA;
                                byte_cnt <= byte_cnt + 2'd1;
                                bit_cnt  <= '0;
                                sda_oe   <= !rw_q && !tx_sr[MESSAGE_LENGTH-1];
                                tx_sr    <= {tx_sr[MESSAGE_LENGTH-2:0], 1'b0};
                            end
                        end
                        STOP: begin
                            // After a NACK the bus idles one bit period (SCL and SDA low) before the STOP edge.
                            if (stop_lead) begin
                                stop_lead <= 1'b0;
                                sda_oe    <= 1'b1;
                            end else begin
                                state  <= DONE;
                                done   <= 1'b1;
                                busy   <= 1'b0;
                                scl    <= 1'b1;
                                sda_oe <= 1'b0;
                            end
                        end
                        default: state <= IDLE;
                    endcase
                end
            end
        end
    end

endmodule
